// File: rtl/cve2_instr_mem_responder.sv
// cve2_instr_mem_responder
// Responder end of the core instruction-fetch interface. Fetch requests are
// granted unless stalled or the outstanding limit is reached. Responses come
// back in order, a fixed number of cycles after the grant, from an internal
// word array. Addresses outside the mapped window return a bus error.
// A side load port writes words into the array, for example to preload
// program images.
//
// Ports:
//   clk_i, rst_ni      clock and asynchronous active-low reset
//   instr_req_i        fetch request
//   instr_addr_i       byte address (bits [1:0] ignored)
//   instr_gnt_o        request accepted this cycle (combinational)
//   instr_rvalid_o     response valid
//   instr_rdata_o      response data (zero when no response)
//   instr_err_o        response is a bus error (zero when no response)
//   stall_i            blocks new grants
//   load_we_i          array write enable
//   load_addr_i        word index for write
//   load_wdata_i       write data
//   outstanding_o      number of accepted but unanswered requests
module cve2_instr_mem_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned AddrW         = $clog2(MemWords),
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,
  input  logic             stall_i,
  input  logic             load_we_i,
  input  logic [AddrW-1:0] load_addr_i,
  input  logic [31:0]      load_wdata_i,
  output logic [CntW-1:0]  outstanding_o
);

  localparam logic [31:0]     WindowBytes = 32'(4 * MemWords);
  localparam logic [CntW-1:0] MaxCnt      = CntW'(MaxOutstanding);

  logic [31:0]            mem [MemWords];

  logic                   accept;
  logic [31:0]            offset;
  logic                   in_range;
  logic [AddrW-1:0]       rd_idx;
  logic [31:0]            rd_data;
  logic                   rvalid;

  logic [ReadLatency-1:0] valid_q, valid_d;
  logic [ReadLatency-1:0] err_q, err_d;
  logic [31:0]            data_q [ReadLatency];
  logic [31:0]            data_d [ReadLatency];

  logic [CntW-1:0]        cnt_q, cnt_d;

  // The last delay stage is the response. A response retiring this cycle
  // frees its slot, so a new grant is still allowed when the counter is full.
  assign rvalid = valid_q[ReadLatency-1];

  always_comb begin
    instr_gnt_o = instr_req_i & ~stall_i & ((cnt_q < MaxCnt) | rvalid);
    accept      = instr_req_i & instr_gnt_o;
  end

  // Address decode. Unsigned wrap-around of the subtraction makes
  // addresses below BaseAddr land outside the window.
  always_comb begin
    offset   = instr_addr_i - BaseAddr;
    in_range = offset < WindowBytes;
    rd_idx   = offset[AddrW+1:2];
    rd_data  = mem[rd_idx];
  end

  // The array is read combinationally in the accept cycle. The load port
  // writes at the clock edge, so a same-cycle write is seen only from the
  // next cycle onward (read-before-write).
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  // Delay line: stage 0 captures the accepted response, and later stages
  // shift every cycle. There is no back-pressure.
  always_comb begin
    valid_d = '0;
    err_d   = '0;
    for (int i = 0; i < int'(ReadLatency); i++) begin
      data_d[i] = '0;
    end
    valid_d[0] = accept;
    err_d[0]   = accept & ~in_range;
    data_d[0]  = (accept & in_range) ? rd_data : 32'h0;
    for (int i = 1; i < int'(ReadLatency); i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < int'(ReadLatency); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int i = 0; i < int'(ReadLatency); i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Outstanding counter. An accept and a retiring response in the same
  // cycle cancel each other out.
  always_comb begin
    cnt_d = cnt_q;
    case ({accept, rvalid})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    instr_rvalid_o = rvalid;
    instr_rdata_o  = rvalid ? data_q[ReadLatency-1] : 32'h0;
    instr_err_o    = rvalid & err_q[ReadLatency-1];
    outstanding_o  = cnt_q;
  end

  a_rvalid_has_outstanding : assert property (
    @(posedge clk_i) disable iff (!rst_ni) instr_rvalid_o |-> (outstanding_o != '0));

  a_outstanding_bounded : assert property (
    @(posedge clk_i) disable iff (!rst_ni) outstanding_o <= MaxCnt);

  a_gnt_known : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !$isunknown(instr_gnt_o));

endmodule
